// File: rtl/router_pkg.sv
// Shared types and header field positions for the router output-port logic.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } state_t;

  localparam int LEN_MSB    = 7;
  localparam int LEN_LSB    = 2;
  localparam int ADDR_MSB   = 1;
  localparam int MARKER_BIT = 8;
  localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;

  // Payload length carried in a header byte.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

  // Destination address carried in a header byte.
  function automatic logic [ADDR_MSB:0] hdr_addr(input logic [7:0] hdr);
    return hdr[ADDR_MSB:0];
  endfunction

  // Running XOR parity over the header and payload bytes.
  function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Received parity byte disagrees with the accumulated parity.
  function automatic logic parity_mismatch(input logic [7:0] acc, input logic [7:0] b);
    return (acc != b);
  endfunction

endpackage

// File: rtl/router_timeout_cnt.sv
// Stall watchdog: counts consecutive stalled cycles and issues a one-cycle
// registered soft_reset pulse when the client leaves a byte unread too long.
module router_timeout_cnt
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int TCNT_W  = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic stall,
  input  logic clear,
  output logic expire,
  output logic soft_reset
);

  logic [TCNT_W-1:0] cnt_r;
  logic              soft_reset_r;

  // The stall that would take the count to TIMEOUT fires the pulse instead.
  assign expire     = stall && (cnt_r == TCNT_W'(TIMEOUT - 1));
  assign soft_reset = soft_reset_r;

  // Stall counter and registered soft-reset pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_r        <= {TCNT_W{1'b0}};
      soft_reset_r <= 1'b0;
    end else begin
      soft_reset_r <= expire;
      if (expire || clear) begin
        cnt_r <= {TCNT_W{1'b0}};
      end else if (stall) begin
        cnt_r <= cnt_r + TCNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/router_out_ctrl.sv
// Read-side controller for one router output port: frames packets from a
// first-word-fall-through FIFO, presents them to the client with a valid
// flag, checks parity and issues the stall-timeout soft reset.
module router_out_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int TCNT_W  = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [8:0] fifo_dout,
  output logic       fifo_rd_en,
  input  logic       read_enb,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       sop,
  output logic       eop,
  output logic       parity_err,
  output logic       soft_reset,
  output logic       busy
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [LEN_W-1:0] cnt_r;
  logic [7:0]       acc_r;
  logic             perr_r;
  logic             vld_s;
  logic             drop_s;
  logic             framing_s;
  logic             accept_s;
  logic             stall_s;
  logic             clear_s;
  logic             expire_s;
  logic             soft_reset_s;

  // Next-state and presentation decode.
  always_comb begin
    state_nxt_s = state_r;
    vld_s       = 1'b0;
    drop_s      = 1'b0;
    framing_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // Held during the soft-reset cycle so the flushing FIFO is never popped.
        if (!fifo_empty && !soft_reset_s) begin
          if (fifo_dout[MARKER_BIT]) begin
            state_nxt_s = HEADER;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HEADER: begin
        vld_s = !fifo_empty;
        if (vld_s && read_enb) begin
          if (hdr_len(fifo_dout[7:0]) == {LEN_W{1'b0}}) begin
            state_nxt_s = PARITY;
          end else begin
            state_nxt_s = PAYLOAD;
          end
        end else begin
          state_nxt_s = HEADER;
        end
      end
      PAYLOAD: begin
        // A header marker mid-payload is a framing error: leave it queued.
        if (!fifo_empty && fifo_dout[MARKER_BIT]) begin
          framing_s   = 1'b1;
          state_nxt_s = HEADER;
        end else begin
          vld_s = !fifo_empty;
          if (vld_s && read_enb && (cnt_r <= LEN_W'(1))) begin
            state_nxt_s = PARITY;
          end else begin
            state_nxt_s = PAYLOAD;
          end
        end
      end
      PARITY: begin
        vld_s = !fifo_empty;
        if (vld_s && read_enb) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign accept_s   = vld_s && read_enb;
  assign stall_s    = vld_s && !read_enb;
  assign clear_s    = !vld_s || accept_s;

  assign vld_out    = vld_s;
  assign data_out   = fifo_dout[7:0];
  assign sop        = vld_s && (state_r == HEADER);
  assign eop        = vld_s && (state_r == PARITY);
  assign fifo_rd_en = accept_s || drop_s;
  assign busy       = (state_r != IDLE);
  assign parity_err = perr_r;
  assign soft_reset = soft_reset_s;

  // State, byte counter, parity accumulator and sticky parity error.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= {LEN_W{1'b0}};
      acc_r   <= 8'h00;
      perr_r  <= 1'b0;
    end else if (soft_reset_s) begin
      state_r <= IDLE;
      cnt_r   <= {LEN_W{1'b0}};
      acc_r   <= 8'h00;
      perr_r  <= perr_r;
    end else if (expire_s) begin
      state_r <= IDLE;
      cnt_r   <= cnt_r;
      acc_r   <= acc_r;
      perr_r  <= perr_r;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        case (state_r)
          HEADER: begin
            cnt_r  <= hdr_len(fifo_dout[7:0]);
            acc_r  <= fifo_dout[7:0];
            perr_r <= 1'b0;
          end
          PAYLOAD: begin
            cnt_r <= cnt_r - LEN_W'(1);
            acc_r <= parity_fold(acc_r, fifo_dout[7:0]);
          end
          PARITY: begin
            perr_r <= parity_mismatch(acc_r, fifo_dout[7:0]);
          end
          default: begin
            cnt_r <= cnt_r;
          end
        endcase
      end else if (framing_s) begin
        perr_r <= 1'b1;
      end else begin
        perr_r <= perr_r;
      end
    end
  end

  router_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TCNT_W  (TCNT_W)
  ) u_timeout (
    .clock      (clock),
    .resetn     (resetn),
    .stall      (stall_s),
    .clear      (clear_s),
    .expire     (expire_s),
    .soft_reset (soft_reset_s)
  );

endmodule

// File: tb/tb_router_out_ctrl.sv
// Scoreboard bench for router_out_ctrl: a FIFO model feeds the DUT, expected
// accepted bytes are queued at stimulus time and checked by a monitor.
module tb_router_out_ctrl;

  logic       clock;
  logic       resetn;
  logic       fifo_empty;
  logic [8:0] fifo_dout;
  logic       fifo_rd_en;
  logic       read_enb;
  logic       vld_out;
  logic [7:0] data_out;
  logic       sop;
  logic       eop;
  logic       parity_err;
  logic       soft_reset;
  logic       busy;

  logic [8:0]  fq[$];
  logic [10:0] exp_q[$];
  int          checks;
  int          failures;
  int          acc_cnt;
  int          sr_seen;
  int          vld_seen;
  logic snap_vld, snap_rd, snap_sr, snap_perr, snap_busy, snap_sop;

  router_out_ctrl #(.TIMEOUT(30), .TCNT_W(5)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .read_enb   (read_enb),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .sop        (sop),
    .eop        (eop),
    .parity_err (parity_err),
    .soft_reset (soft_reset),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? 9'h000 : fq[0];
  endtask

  task automatic push_w(input logic [8:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic expect_b(input logic s, input logic e, input logic [7:0] b);
    exp_q.push_back({1'b1, s, e, b});
  endtask

  // Queue a whole packet (up to 3 payload bytes) and its expected accepts.
  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] par);
    logic [7:0] pl [3];
    pl[0] = b0; pl[1] = b1; pl[2] = b2;
    push_w({1'b1, hdr});
    expect_b(1'b1, 1'b0, hdr);
    for (int i = 0; i < n; i++) begin
      push_w({1'b0, pl[i]});
      expect_b(1'b0, 1'b0, pl[i]);
    end
    push_w({1'b0, par});
    expect_b(1'b0, 1'b1, par);
  endtask

  // One clock: sample outputs mid-cycle, then let the FIFO model react to the edge.
  task automatic cyc();
    @(negedge clock);
    snap_vld  = vld_out;
    snap_rd   = fifo_rd_en;
    snap_sr   = soft_reset;
    snap_perr = parity_err;
    snap_busy = busy;
    snap_sop  = sop;
    if (vld_out && read_enb) acc_cnt++;
    @(posedge clock);
    #1;
    if (snap_sr) begin
      fq.delete();
    end else if (snap_rd && fq.size() > 0) begin
      void'(fq.pop_front());
    end
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    acc_cnt  = 0;
    resetn   = 1'b0;
    read_enb = 1'b0;
    refresh();

    // Monitor: every accepted byte must match the next scoreboard entry.
    fork
      forever begin
        logic [10:0] item;
        @(negedge clock);
        if (resetn && vld_out && read_enb) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL accept_unexpected actual=%0h expected=none", data_out);
          end else begin
            item = exp_q.pop_front();
            chk("accept", 32'({fifo_rd_en, sop, eop, data_out}), 32'(item));
          end
        end
      end
    join_none

    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", 32'({vld_out, fifo_rd_en, sop, eop, soft_reset, parity_err, busy}), 32'(7'b0));
    resetn = 1'b1;

    // Good packet, L=3, client always ready.
    read_enb = 1'b1;
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D);
    cyc();
    chk("t1_idle_gap", 32'({snap_vld, snap_busy}), 32'(2'b00));
    acc_cnt = 0;
    run(5);
    chk("t1_accepts", 32'(acc_cnt), 32'(5));
    cyc();
    chk("t1_perr", 32'({snap_perr, snap_busy}), 32'(2'b00));

    // Corrupted parity byte.
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0C);
    cyc();
    acc_cnt = 0;
    run(5);
    chk("t2_accepts", 32'(acc_cnt), 32'(5));
    cyc();
    chk("t2_perr_set", 32'(snap_perr), 32'(1));

    // L=0 packet; its header accept clears the sticky error.
    send_pkt(8'h02, 0, 8'h00, 8'h00, 8'h00, 8'h02);
    cyc();
    chk("t3_perr_sticky", 32'(snap_perr), 32'(1));
    acc_cnt = 0;
    run(2);
    chk("t3_accepts", 32'(acc_cnt), 32'(2));
    cyc();
    chk("t3_perr_clear", 32'(snap_perr), 32'(0));

    // Timeout: header stalled for 30 cycles.
    read_enb = 1'b0;
    push_w({1'b1, 8'h0D});
    cyc();
    sr_seen  = 0;
    vld_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (snap_sr) sr_seen++;
      if (snap_vld) vld_seen++;
    end
    chk("t4_no_early_sr", 32'(sr_seen), 32'(0));
    chk("t4_stall_vld", 32'(vld_seen), 32'(30));
    cyc();
    chk("t4_sr_pulse", 32'({snap_sr, snap_busy, snap_rd, snap_vld}), 32'(4'b1000));
    cyc();
    chk("t4_sr_one_cycle", 32'({snap_sr, snap_busy, snap_vld}), 32'(3'b000));

    // Timeout restart: accept at stall cycle 29, then 30 more stalls.
    push_w({1'b1, 8'h0D});
    expect_b(1'b1, 1'b0, 8'h0D);
    push_w({1'b0, 8'h11});
    cyc();
    run(28);
    read_enb = 1'b1;
    cyc();
    read_enb = 1'b0;
    sr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (snap_sr) sr_seen++;
    end
    chk("t4b_restart_no_sr", 32'(sr_seen), 32'(0));
    cyc();
    chk("t4b_sr_after_restart", 32'({snap_sr, snap_busy}), 32'(2'b10));
    cyc();

    // Stray non-header word in IDLE is dropped silently.
    push_w({1'b0, 8'hAA});
    cyc();
    chk("t5_drop", 32'({snap_rd, snap_vld, snap_busy}), 32'(3'b100));
    cyc();
    chk("t5_after", 32'({snap_rd, snap_vld, snap_busy}), 32'(3'b000));

    // Framing error: new header after 1 of 3 payload bytes.
    read_enb = 1'b1;
    push_w({1'b1, 8'h0D}); expect_b(1'b1, 1'b0, 8'h0D);
    push_w({1'b0, 8'h11}); expect_b(1'b0, 1'b0, 8'h11);
    push_w({1'b1, 8'h06}); expect_b(1'b1, 1'b0, 8'h06);
    push_w({1'b0, 8'h22}); expect_b(1'b0, 1'b0, 8'h22);
    push_w({1'b0, 8'h24}); expect_b(1'b0, 1'b1, 8'h24);
    run(3);
    cyc();
    chk("t6_frame_no_pop", 32'({snap_vld, snap_rd, snap_busy}), 32'(3'b001));
    cyc();
    chk("t6_perr_header", 32'({snap_perr, snap_sop}), 32'(2'b11));
    run(2);
    cyc();
    chk("t6_perr_clear", 32'({snap_perr, snap_busy}), 32'(2'b00));

    // Asynchronous reset in PAYLOAD.
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D);
    run(3);
    chk("t7_in_payload", 32'(busy), 32'(1));
    resetn = 1'b0;
    fq.delete();
    exp_q.delete();
    refresh();
    #1;
    chk("t7_async_reset", 32'({vld_out, fifo_rd_en, sop, eop, soft_reset, parity_err, busy}), 32'(7'b0));
    @(posedge clock);
    #1;
    resetn = 1'b1;
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D);
    cyc();
    acc_cnt = 0;
    run(5);
    chk("t7_accepts", 32'(acc_cnt), 32'(5));
    cyc();
    chk("t7_perr", 32'({snap_perr, snap_busy}), 32'(2'b00));

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_out_ctrl.md
# router_out_ctrl

Read-side controller for one router output port. Sits between one first-word-fall-through output FIFO and the destination client. Frames each packet (header, payload, parity), presents bytes with a valid flag, and checks parity. Also issues the per-port soft reset when the client leaves a valid byte unread too long; that soft reset clears the FIFO and returns the input FSM to address decode.

## Interface
- TIMEOUT, 30: consecutive stalled cycles before soft_reset fires.
- TCNT_W, 5: width of the timeout counter; must satisfy 2^TCNT_W > TIMEOUT.
- clock  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- fifo_empty  in  1  FIFO has no word.
- fifo_dout  in  9  FIFO head word: [8] header marker, [7:0] byte.
- fifo_rd_en  out  1  pop the FIFO head this cycle.
- read_enb  in  1  client accepts the presented byte this cycle.
- vld_out  out  1  data_out holds a valid byte.
- data_out  out  8  presented byte, equal to fifo_dout[7:0].
- sop  out  1  presented byte is a header.
- eop  out  1  presented byte is the parity byte.
- parity_err  out  1  parity mismatch on the last completed packet; sticky until the next header is accepted.
- soft_reset  out  1  one-cycle timeout pulse to the FIFO and the input FSM.
- busy  out  1  packet in progress: state is not IDLE.

## Operation
- Header layout: [7:2] payload length L (0..63), [1:0] destination address. Packet = header, then L payload bytes, then 1 parity byte.
- Expected parity = XOR of the header and all payload bytes.
- States:
  - IDLE
    - !fifo_empty && fifo_dout[8]=1 → HEADER; pop nothing.
    - !fifo_empty && fifo_dout[8]=0 → stray byte; pop it silently (fifo_rd_en=1, vld_out=0); stay in IDLE.
  - HEADER
    - On accept: latch L into the byte counter; parity accumulator = byte; clear parity_err.
    - L=0 → PARITY; else → PAYLOAD.
  - PAYLOAD
    - On accept: accumulator ^= byte; counter decrements.
    - Counter reaching 0 on accept → PARITY.
    - Head word with fifo_dout[8]=1 → framing error; set parity_err; → HEADER; do not pop.
  - PARITY
    - On accept: parity_err = (byte != accumulator); → IDLE.
- Presentation and handshake:
  - vld_out = !fifo_empty in HEADER, PAYLOAD and PARITY.
  - Accept = vld_out && read_enb; fifo_rd_en = accept, except for the IDLE drop case.
  - sop = vld_out in HEADER; eop = vld_out in PARITY.
- Timeout:
  - A stall cycle is one with vld_out=1 && read_enb=0. Each stall cycle increments the counter.
  - Any accept, or any cycle with vld_out=0, clears the counter.
  - A stall cycle with counter = TIMEOUT-1 registers soft_reset=1 for the next cycle, clears the counter, and forces IDLE.
- Soft reset: the FIFO empties in response. No pop is issued during the soft_reset cycle; the parity accumulator is cleared.

## Timing
- Reset values: state IDLE; counters 0; vld_out, sop, eop, fifo_rd_en, soft_reset, parity_err and busy all 0.
- vld_out, data_out, sop, eop and fifo_rd_en are combinational from state plus FIFO/client inputs, giving zero-latency pass-through. soft_reset and parity_err are registered.
- IDLE→HEADER costs one cycle, so the header is presented one cycle after the FIFO goes non-empty.
- Back-to-back accepts sustain 1 byte/cycle. The next header follows the parity accept after one IDLE cycle.
- FIFO empty mid-packet: vld_out=0, state holds, timeout counter clears.
- Reset asserted mid-packet: immediate return to reset values, with no partial pop.

## Structure
- router_pkg holds:
  - state enum: IDLE, HEADER, PAYLOAD, PARITY;
  - header field positions LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1;
  - FIFO marker bit index 8.
- Sub-module router_timeout_cnt: takes stall, clear and TIMEOUT; produces the registered soft_reset pulse. Reused on all three ports.

## Test plan
- Header 8'h0D (L=3, addr 1), payload 11,22,33, parity 8'h0D^11^22^33, read_enb held high → 5 accepts on consecutive cycles; sop on the first, eop on the fifth; parity_err=0.
- Same packet with parity byte corrupted by 8'h01 → parity_err=1 the cycle after the parity accept; cleared on the next header accept.
- Header 8'h02 (L=0), parity 8'h02 → HEADER then PARITY; 2 accepts; parity_err=0.
- Valid header presented, read_enb=0 for 30 cycles → soft_reset=1 exactly on cycle 31 for one cycle; state IDLE; no pop. The same with read_enb pulsed at cycle 29 → no soft_reset and the counter restarts.
- Stray word {0,8'hAA} at FIFO head in IDLE → popped with vld_out=0. Header marker arriving after 1 of 3 payload bytes → parity_err=1; state HEADER; the marker word is not popped.
- resetn pulsed low while in PAYLOAD → all outputs 0 asynchronously; the next header is processed normally.
